// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the LFSR generator/checker pair: state encoding,
// default geometry, and the single recurrence used on both sides.
package lfsr_checker_pkg;

  localparam int DEF_N   = 4;
  localparam int DEF_TAP = 3;
  localparam int MAX_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // One step of the Fibonacci recurrence on the low n bits of s:
  // shift right by one, feed s[0]^s[tap] into bit n-1. Bits above n are zero.
  function automatic logic [MAX_W-1:0] pred_step(input logic [MAX_W-1:0] s,
                                                 input int n,
                                                 input int tap);
    logic [MAX_W-1:0] r;
    r = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < n - 1) begin
        r[i] = s[i+1];
      end else begin
        r[i] = 1'b0;
      end
    end
    r[n-1] = s[0] ^ s[tap];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational N-bit next-state function of the Fibonacci LFSR.
module lfsr_step
  import lfsr_checker_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int TAP = DEF_TAP
) (
  input  logic [N-1:0] i_state,
  output logic [N-1:0] o_next
);

  // Apply the shared recurrence to the current word.
  always_comb begin
    o_next = N'(pred_step(MAX_W'(i_state), N, TAP));
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: predicts each sample from the previous one,
// acquires lock after LOCK_CNT consecutive matches, drops lock after
// LOSS_CNT consecutive mismatches, and counts mismatches seen while locked.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int TAP      = DEF_TAP,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_valid,
  input  logic [N-1:0]     i_data_in,
  input  logic             i_clr_cnt,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] LOSS_V = RUN_W'(LOSS_CNT);

  logic [N-1:0]     r_prev;
  state_t           r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;

  logic [N-1:0]     w_pred;
  logic             w_match;
  logic [RUN_W-1:0] w_run_inc;
  state_t           w_state_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  lfsr_step #(
    .N   (N),
    .TAP (TAP)
  ) u_step (
    .i_state (r_prev),
    .o_next  (w_pred)
  );

  // An all-zero word is the LFSR lock-up state and never counts as a match.
  always_comb begin
    w_match   = (i_data_in == w_pred) && (i_data_in != {N{1'b0}});
    w_run_inc = r_run + {{(RUN_W-1){1'b0}}, 1'b1};
  end

  // Next-state decision for the lock FSM, run counter and error pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_err_nxt   = 1'b0;
    if (i_data_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = {RUN_W{1'b0}};
        end
        ST_HUNT: begin
          if (w_match) begin
            if (w_run_inc == LOCK_V) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = {RUN_W{1'b0}};
            end else begin
              w_run_nxt   = w_run_inc;
            end
          end else begin
            w_run_nxt = {RUN_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_run_nxt = {RUN_W{1'b0}};
          end else begin
            w_err_nxt = 1'b1;
            if (w_run_inc == LOSS_V) begin
              w_state_nxt = ST_HUNT;
              w_run_nxt   = {RUN_W{1'b0}};
            end else begin
              w_run_nxt   = w_run_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
    end
  end

  // Saturating error counter; a clear request beats a simultaneous error.
  always_comb begin
    w_cnt_nxt = r_err_count;
    if (i_clr_cnt) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_err_nxt && !(&r_err_count)) begin
      w_cnt_nxt = r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_err_count;
    end
  end

  // State and registered outputs; every valid sample becomes the new reference.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev      <= {N{1'b0}};
      r_state     <= ST_IDLE;
      r_run       <= {RUN_W{1'b0}};
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= {CNT_W{1'b0}};
    end else begin
      if (i_data_valid) begin
        r_prev <= i_data_in;
      end
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err       <= w_err_nxt;
      r_err_count <= w_cnt_nxt;
    end
  end

  assign o_locked    = r_locked;
  assign o_err       = r_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with hand-computed expectations (N=4, TAP=3).
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        data_valid;
  logic [3:0]  data_in;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  int n_checks;
  int n_fail;

  lfsr_checker #(
    .N        (4),
    .TAP      (3),
    .LOCK_CNT (4),
    .LOSS_CNT (3),
    .CNT_W    (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_valid (data_valid),
    .i_data_in    (data_in),
    .i_clr_cnt    (clr_cnt),
    .o_locked     (locked),
    .o_err        (err),
    .o_err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let an edge pass, then check all three outputs.
  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic c,
                      input logic e_lock, input logic e_err, input logic [15:0] e_cnt);
    data_valid = v;
    data_in    = d;
    clr_cnt    = c;
    @(posedge clk);
    #1;
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, e_lock});
    check({tag, ".err"},    {31'd0, err},    {31'd0, e_err});
    check({tag, ".cnt"},    {16'd0, err_count}, {16'd0, e_cnt});
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 4'b0000;
    clr_cnt    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scenario 1: lock onto 1000,1100,1110,1111,0111.
  task automatic acquire(input string tag);
    step({tag, ".s1"}, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 16'd0);
    step({tag, ".s2"}, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 16'd0);
    step({tag, ".s3"}, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 16'd0);
    step({tag, ".s4"}, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 16'd0);
    step({tag, ".s5"}, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 4'b0000;
    clr_cnt    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.locked", {31'd0, locked}, 32'd0);
    check("rst.err",    {31'd0, err},    32'd0);
    check("rst.cnt",    {16'd0, err_count}, 32'd0);
    rst = 1'b0;

    // 1. acquisition
    acquire("t1");

    // 2. single corrupted word -> two errors, lock held
    step("t2.bad",  1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 16'd1);
    step("t2.succ", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 16'd2);
    step("t2.ok1",  1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 16'd2);
    step("t2.ok2",  1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 16'd2);

    // 3. three mismatches drop lock; five correct words regain it
    step("t3.m1", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd3);
    step("t3.m2", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd4);
    step("t3.m3", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 16'd5);
    step("t3.r1", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 16'd5);
    step("t3.r2", 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 16'd5);
    step("t3.r3", 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 16'd5);
    step("t3.r4", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 16'd5);
    step("t3.r5", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 16'd5);

    // 4. all-zero stream never locks and never errors
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step("t4.zero", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
    end

    // 5. gapped valid keeps lock; clear wins against simultaneous error
    do_reset();
    acquire("t5");
    step("t5.v1", 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.g1", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.v2", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.g2", 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.v3", 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.g3", 1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.v4", 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.g4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd0);
    step("t5.e1", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd1);
    step("t5.ok", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 16'd1);
    step("t5.e2", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 16'd2);
    step("t5.clr", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 16'd0);
    step("t5.idle", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd0);

    // 6. asynchronous reset mid-LOCKED, between edges
    do_reset();
    acquire("t6a");
    step("t6.err", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 16'd1);
    data_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t6.async.locked", {31'd0, locked}, 32'd0);
    check("t6.async.err",    {31'd0, err},    32'd0);
    check("t6.async.cnt",    {16'd0, err_count}, 32'd0);
    #1;
    rst = 1'b0;
    acquire("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
